uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin, packet-locking arbiter that shares the UART TX FIFO write port (`i_valid_tx` / `i_tx_sys_data` / `o_tx_full`) between `N_REQ` system requesters. One requester is granted at a time. It owns the port until it has sent its packet (`last`), hit a burst limit, or gone idle too long. The arbiter sits between the system-side producers and the UART top in normal mode (`i_test_mux` = 0).

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: maximum bytes per grant before forced release, ≥1.
- `IDLE_TIMEOUT`, 255: consecutive granted cycles with requester valid low before forced release, ≥1.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_req_valid`  in  N_REQ  per-requester byte valid.
- `i_req_data`  in  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- `i_req_last`  in  N_REQ  per-requester marker: the current byte ends the packet.
- `i_tx_full`  in  1  UART TX FIFO full.
- `o_req_ready`  out  N_REQ  per-requester byte accepted this cycle when ANDed with valid.
- `o_valid_tx`  out  1  write strobe to the UART TX FIFO.
- `o_tx_data`  out  8  byte to the UART TX FIFO.
- `o_grant`  out  N_REQ  one-hot current grant; all zero when idle.
- `o_busy`  out  1  state is XFER.
- `o_burst_cnt`  out  $clog2(MAX_BURST+1)  bytes accepted in the current grant.
- `o_state`  out  1  test signal: 0 = IDLE, 1 = XFER.

## Operation
- State machine with two states.
  - **IDLE:** if any `i_req_valid` is set, select the first set bit searching from `ptr` upward modulo `N_REQ`. Register the one-hot `o_grant`, clear the burst count and idle counter, and go to XFER. Otherwise stay in IDLE.
  - **XFER:** let g be the granted index.
    - `o_req_ready[g]` = `!i_tx_full`. All other ready bits are 0.
    - `o_valid_tx` = `i_req_valid[g] && !i_tx_full`.
    - `o_tx_data` = `i_req_data[g]` while in XFER, and 0 in IDLE.
    - A transfer occurs when `o_valid_tx` = 1. Each transfer increments `o_burst_cnt`.
- Release from XFER to IDLE happens on the first of these:
  - a transfer with `i_req_last[g]` = 1;
  - a transfer that makes `o_burst_cnt` = `MAX_BURST`;
  - the idle counter reaching `IDLE_TIMEOUT`.
- On release:
  - `ptr` <= (g+1) mod `N_REQ`;
  - `o_grant` <= 0.
- Idle counter:
  - increments each XFER cycle with `i_req_valid[g]` = 0 and `i_tx_full` = 0;
  - holds while `i_tx_full` = 1, so backpressure never causes a timeout;
  - clears on any transfer.
- Valid dropping mid-packet does not release the grant; the packet stays locked until a release condition occurs.
- Forced release by burst limit or timeout does not discard anything. The requester continues on its next grant, with no byte lost or duplicated.
- Requests from non-granted requesters are ignored until the next IDLE.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, `ptr` = 0, `o_grant` = 0, `o_busy` = 0;
  - `o_burst_cnt` = 0, idle counter = 0;
  - `o_valid_tx` = 0, `o_tx_data` = 0, `o_req_ready` = 0.
- Reset asserted during XFER aborts the grant. The partial packet is not resumed, and `ptr` returns to 0.
- Arbitration latency:
  - cycle 0: valid is seen in IDLE;
  - cycle 1: grant is registered and the first transfer is possible if `!i_tx_full`.
- Each burst ends with exactly one IDLE cycle, so the minimum gap between bursts from different or the same requester is 1 cycle.
- `o_valid_tx`, `o_tx_data` and `o_req_ready` are combinational from registered state plus `i_req_valid`, `i_req_data` and `i_tx_full`.
  - These outputs have no registered delay.
  - Because the UART qualifies writes with `!full`, no byte is presented while the FIFO is full.
- `i_req_last` and the burst limit on the same transfer produce a single release. `ptr` advances once.
- `i_req_valid` is sampled only in IDLE for arbitration. Inputs are synchronous to `clk`.

## Test plan
- **Single requester:** requester 2 sends a 3-byte packet 0xA1, 0xA2, 0xA3 (last on 0xA3) with FIFO not full.
  - Grant `0100` from cycle 1.
  - `o_valid_tx` high on cycles 1-3 with data A1, A2, A3.
  - IDLE on cycle 4, `ptr` = 3.
- **Round-robin:** all 4 requesters continuously send 1-byte packets.
  - Grant order 0, 1, 2, 3, 0, ….
  - Each byte is followed by 1 IDLE cycle.
- **Backpressure:** `i_tx_full` held high for 10 cycles mid-packet.
  - `o_valid_tx` = 0 and `o_req_ready[g]` = 0 throughout.
  - No timeout with `IDLE_TIMEOUT` = 4.
  - The packet resumes intact after full drops.
- **Burst limit:** with `MAX_BURST` = 4, requester 1 sends 6 bytes 0x10..0x15 while requester 3 is valid.
  - After 0x13, grant moves to 3.
  - Requester 1 later resumes with 0x14, 0x15.
  - `o_burst_cnt` peaks at 4.
- **Idle timeout:** with `IDLE_TIMEOUT` = 4, requester 0 sends one byte without last, then drops valid.
  - Release occurs after 4 idle cycles and `ptr` = 1.
- **Reset mid-XFER:** assert `rst_n` = 0 during a burst.
  - All outputs go to 0 immediately.
  - After release, a request from requester 3 alone is granted within 1 cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter for the UART TX FIFO write port
// A grant is held until packet end, burst limit or idle timeout; byte path is combinational.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             i_req_valid,
  input  logic [8*N_REQ-1:0]           i_req_data,
  input  logic [N_REQ-1:0]             i_req_last,
  input  logic                         i_tx_full,
  output logic [N_REQ-1:0]             o_req_ready,
  output logic                         o_valid_tx,
  output logic [7:0]                   o_tx_data,
  output logic [N_REQ-1:0]             o_grant,
  output logic                         o_busy,
  output logic [$clog2(MAX_BURST+1)-1:0] o_burst_cnt,
  output logic                         o_state
);

  localparam int PW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [BW-1:0]   burst_cnt;
  logic [TW-1:0]   idle_cnt;

  logic            found;
  logic [PW-1:0]   sel;
  logic            g_valid;
  logic            g_last;
  logic            release_now;
  logic [PW-1:0]   ptr_next;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin : arb
    int idx;
    logic [PW-1:0] cand;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PW'(idx);
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_tx_data   = '0;
    g_valid     = 1'b0;
    g_last      = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (state == XFER && gidx == PW'(k)) begin
        o_req_ready[k] = !i_tx_full;
        o_tx_data      = i_req_data[8*k +: 8];
        g_valid        = i_req_valid[k];
        g_last         = i_req_last[k];
      end
    end
    o_valid_tx = g_valid && !i_tx_full;
  end

  // Last byte and burst limit on the same transfer fold into one release.
  assign release_now = (o_valid_tx && (g_last || burst_cnt == BW'(MAX_BURST - 1))) ||
                       (state == XFER && !g_valid && !i_tx_full &&
                        idle_cnt == TW'(IDLE_TIMEOUT - 1));

  assign ptr_next = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      o_grant   <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= XFER;
            gidx      <= sel;
            o_grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        XFER: begin
          if (o_valid_tx) begin
            burst_cnt <= burst_cnt + 1'b1;
            idle_cnt  <= '0;
          end else if (!i_tx_full) begin
            idle_cnt  <= idle_cnt + 1'b1;
          end
          if (release_now) begin
            state   <= IDLE;
            o_grant <= '0;
            ptr     <= ptr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy      = (state == XFER);
  assign o_state     = state;
  assign o_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic        tx_full = 1'b0;
  logic [3:0]  req_ready;
  logic        valid_tx;
  logic [7:0]  tx_data;
  logic [3:0]  grant;
  logic        busy;
  logic [2:0]  burst_cnt;
  logic        state;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(4), .IDLE_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .i_tx_full(tx_full),
    .o_req_ready(req_ready), .o_valid_tx(valid_tx), .o_tx_data(tx_data),
    .o_grant(grant), .o_busy(busy), .o_burst_cnt(burst_cnt), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    req_valid[k]       = v;
    req_data[8*k +: 8] = d;
    req_last[k]        = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic xfer_check(input string tag, input logic [3:0] g, input logic [7:0] d);
    check({tag, "_valid"}, valid_tx, 1);
    check({tag, "_grant"}, grant, g);
    check({tag, "_data"}, tx_data, d);
  endtask

  initial begin
    // reset state
    do_reset();
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid_tx, 0);
    check("rst_data", tx_data, 0);
    check("rst_ready", req_ready, 0);
    check("rst_burst", burst_cnt, 0);
    check("rst_ptr", dut.ptr, 0);

    // single requester 2, 3-byte packet
    set_req(2, 1, 8'hA1, 0); #1;
    check("t1_c0_state", state, 0);
    check("t1_c0_valid", valid_tx, 0);
    cyc(); #1;
    xfer_check("t1_c1", 4'b0100, 8'hA1);
    check("t1_c1_ready", req_ready, 4'b0100);
    cyc(); set_req(2, 1, 8'hA2, 0); #1;
    xfer_check("t1_c2", 4'b0100, 8'hA2);
    cyc(); set_req(2, 1, 8'hA3, 1); #1;
    xfer_check("t1_c3", 4'b0100, 8'hA3);
    cyc(); set_req(2, 0, 8'h00, 0); #1;
    check("t1_c4_state", state, 0);
    check("t1_c4_grant", grant, 0);
    check("t1_c4_ptr", dut.ptr, 3);

    // round-robin, all four sending 1-byte packets
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, 1, 8'h30 + 8'(k), 1);
    #1;
    for (int i = 0; i < 8; i++) begin
      check("rr_idle_state", state, 0);
      check("rr_idle_ready", req_ready, 0);
      cyc(); #1;
      xfer_check("rr", 4'b0001 << (i % 4), 8'h30 + 8'(i % 4));
      cyc(); #1;
    end

    // backpressure: full for 10 cycles with valid low, no timeout
    do_reset();
    set_req(1, 1, 8'h51, 0); #1;
    cyc(); #1;
    xfer_check("bp_c1", 4'b0010, 8'h51);
    cyc(); set_req(1, 0, 8'h52, 0); tx_full = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      check("bp_full_valid", valid_tx, 0);
      check("bp_full_ready", req_ready, 0);
      check("bp_full_grant", grant, 4'b0010);
      cyc(); #1;
    end
    tx_full = 1'b0; set_req(1, 1, 8'h52, 0); #1;
    xfer_check("bp_resume1", 4'b0010, 8'h52);
    check("bp_resume1_ready", req_ready, 4'b0010);
    cyc(); set_req(1, 1, 8'h53, 1); #1;
    xfer_check("bp_resume2", 4'b0010, 8'h53);
    cyc(); set_req(1, 0, 8'h00, 0); #1;
    check("bp_end_state", state, 0);

    // burst limit: requester 1 sends 0x10..0x15 while requester 3 waits
    do_reset();
    set_req(1, 1, 8'h10, 0);
    set_req(3, 1, 8'hC3, 1); #1;
    for (int i = 0; i < 4; i++) begin
      cyc(); set_req(1, 1, 8'h10 + 8'(i), 0); #1;
      xfer_check("bl_first", 4'b0010, 8'h10 + 8'(i));
      check("bl_cnt", burst_cnt, i);
    end
    cyc(); set_req(1, 1, 8'h14, 0); #1;
    check("bl_rel_state", state, 0);
    check("bl_peak_cnt", burst_cnt, 4);
    cyc(); #1;
    xfer_check("bl_req3", 4'b1000, 8'hC3);
    cyc(); set_req(3, 0, 8'h00, 0); #1;
    check("bl_gap_state", state, 0);
    cyc(); #1;
    xfer_check("bl_resume14", 4'b0010, 8'h14);
    check("bl_resume_cnt", burst_cnt, 0);
    cyc(); set_req(1, 1, 8'h15, 1); #1;
    xfer_check("bl_resume15", 4'b0010, 8'h15);
    cyc(); set_req(1, 0, 8'h00, 0); #1;
    check("bl_end_state", state, 0);

    // idle timeout: one byte without last, then valid drops
    do_reset();
    set_req(0, 1, 8'h77, 0); #1;
    cyc(); #1;
    xfer_check("to_c1", 4'b0001, 8'h77);
    cyc(); set_req(0, 0, 8'h00, 0); #1;
    for (int i = 0; i < 4; i++) begin
      check("to_hold_busy", busy, 1);
      cyc(); #1;
    end
    check("to_rel_state", state, 0);
    check("to_rel_ptr", dut.ptr, 1);

    // reset mid-XFER
    do_reset();
    set_req(2, 1, 8'hE1, 0); #1;
    cyc(); #1;
    xfer_check("rx_c1", 4'b0100, 8'hE1);
    #1 rst_n = 1'b0;
    #1;
    check("rx_valid", valid_tx, 0);
    check("rx_data", tx_data, 0);
    check("rx_ready", req_ready, 0);
    check("rx_grant", grant, 0);
    check("rx_busy", busy, 0);
    check("rx_ptr", dut.ptr, 0);
    cyc(); rst_n = 1'b1;
    set_req(2, 0, 8'h00, 0);
    set_req(3, 1, 8'hD3, 1); #1;
    check("rx_idle_state", state, 0);
    cyc(); #1;
    xfer_check("rx_req3", 4'b1000, 8'hD3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
